// File: rtl/mmio_store_ctrl.sv
// Store-side MMIO controller: UART TX holding register, cycle/instruction counters, note timer.
// Optional LED register at 0x80000030 is built only when MMIO_LED_EN is defined.
module mmio_store_ctrl #(
  parameter int unsigned CLK_COUNTS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  we,
  input  logic        inst_retire,
  input  logic        uart_tx_ready,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  output logic        trmt_full,
  output logic [31:0] counter_cycle,
  output logic [31:0] counter_inst,
  output logic        note_finished,
  output logic [5:0]  leds
);

  localparam logic [13:0] OffUart   = 14'h002;
  localparam logic [13:0] OffCntRst = 14'h006;
  localparam logic [13:0] OffLed    = 14'h00c;
  localparam logic [13:0] OffNote   = 14'h400;
  localparam logic [31:0] PrescLast = 32'(CLK_COUNTS - 1);

  logic        hit;
  logic [13:0] offset;
  logic        uart_load, cnt_clear, note_load;

  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] counter_cycle_q, counter_cycle_d;
  logic [31:0] counter_inst_q, counter_inst_d;
  logic [31:0] note_cnt_q, note_cnt_d;
  logic [31:0] presc_q, presc_d;

  // Address bits outside the decoded window are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{addr[29:16], addr[1:0]};

  assign hit       = (we != 4'b0000) && (addr[31:30] == 2'b10);
  assign offset    = addr[15:2];
  // A full register may still accept a byte on the cycle it is being drained.
  assign uart_load = hit && (offset == OffUart) && we[0] &&
                     (!tx_valid_q || uart_tx_ready);
  assign cnt_clear = hit && (offset == OffCntRst);
  assign note_load = hit && (offset == OffNote) && (we == 4'b1111);

  always_comb begin
    tx_valid_d      = tx_valid_q;
    tx_data_d       = tx_data_q;
    counter_cycle_d = counter_cycle_q + 32'd1;
    counter_inst_d  = counter_inst_q + {31'd0, inst_retire};
    note_cnt_d      = note_cnt_q;
    presc_d         = presc_q;

    if (uart_load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = din[7:0];
    end else if (tx_valid_q && uart_tx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (cnt_clear) begin
      counter_cycle_d = '0;
      counter_inst_d  = '0;
    end

    if (note_load) begin
      note_cnt_d = din;
      presc_d    = '0;
    end else if (note_cnt_q != '0) begin
      if (presc_q >= PrescLast) begin
        note_cnt_d = note_cnt_q - 32'd1;
        presc_d    = '0;
      end else begin
        presc_d = presc_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid_q      <= 1'b0;
      tx_data_q       <= '0;
      counter_cycle_q <= '0;
      counter_inst_q  <= '0;
      note_cnt_q      <= '0;
      presc_q         <= '0;
    end else begin
      tx_valid_q      <= tx_valid_d;
      tx_data_q       <= tx_data_d;
      counter_cycle_q <= counter_cycle_d;
      counter_inst_q  <= counter_inst_d;
      note_cnt_q      <= note_cnt_d;
      presc_q         <= presc_d;
    end
  end

  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_data_q;
  assign trmt_full     = tx_valid_q;
  assign counter_cycle = counter_cycle_q;
  assign counter_inst  = counter_inst_q;
  assign note_finished = (note_cnt_q == '0);

`ifdef MMIO_LED_EN
  logic [5:0] leds_q;
  logic       led_load;

  assign led_load = hit && (offset == OffLed) && we[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_q <= '0;
    end else if (led_load) begin
      leds_q <= din[5:0];
    end
  end

  assign leds = leds_q;
`else
  logic unused_led;
  assign unused_led = ^OffLed;
  assign leds       = '0;
`endif

endmodule

// File: doc/mmio_store_ctrl.md
# mmio_store_ctrl

Store-side memory-mapped I/O controller for the RISC-V core; the write counterpart of the data-memory read select. It decodes core stores that target the I/O region (addr[31:30] = 2'b10) and owns the state those stores change: the UART transmit holding register with its valid/ready handshake, the cycle and instruction counters, the note-duration timer, and an optional LED register. Its status outputs (`trmt_full`, `counter_cycle`, `counter_inst`, `note_finished`) feed the load-side read mux.

## Interface
- `CLK_COUNTS`, default 1: cycles per note-timer decrement (≥1).
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `addr`  in  32  store address from the memory stage.
- `din`  in  32  store data, already lane-aligned.
- `we`  in  4  byte write enables; 4'b0000 means no store.
- `inst_retire`  in  1  one instruction retired this cycle.
- `uart_tx_ready`  in  1  UART transmitter can accept a byte.
- `uart_tx_valid`  out  1  holding register occupied.
- `uart_tx_data`  out  8  holding register contents.
- `trmt_full`  out  1  equals `uart_tx_valid`; status to the read mux.
- `counter_cycle`  out  32  free-running cycle counter.
- `counter_inst`  out  32  retired-instruction counter.
- `note_finished`  out  1  note timer is at zero.
- `leds`  out  6  LED register.

## Operation
- A store hits the block when `we != 0` and addr[31:30] = 2'b10. Decode uses addr[15:2]; addr[29:16] and addr[1:0] are ignored. Hits to undecoded offsets have no effect.
- **0x80000008, UART TX:** needs `we[0]`; `din[7:0]` is the byte.
  - If the holding register is empty, or is being drained this cycle (`uart_tx_valid && uart_tx_ready`), the byte is loaded and `uart_tx_valid` is 1 next cycle.
  - Otherwise the byte is silently dropped. Software polls `trmt_full`.
- **UART handshake:** `uart_tx_data` is stable while `uart_tx_valid` = 1. A transfer occurs on any edge with both `uart_tx_valid` and `uart_tx_ready` high. Without a simultaneous load, `uart_tx_valid` is 0 next cycle.
- **0x80000018, counter reset:** any nonzero `we` zeroes both counters next cycle. Reset wins over same-cycle increments, so both read 0, not 1.
- **Counters:**
  - `counter_cycle` increments every cycle.
  - `counter_inst` increments when `inst_retire` = 1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- **0x80001000, note length:** only `we` = 4'b1111 is accepted; partial writes are ignored.
  - Loads `din` into a 32-bit down-counter and clears the prescaler.
  - While the count is nonzero, it decrements once every `CLK_COUNTS` cycles.
  - `note_finished` = (count == 0), driven combinationally from the register.
  - Writing 0 leaves `note_finished` = 1.
  - Writing mid-note reloads immediately; there is no queuing.
- **0x80000030, LEDs:** `we[0]` loads `din[5:0]` into `leds` (see Configuration).

## Timing
- All writes take effect on the edge that samples the store; new values are visible the following cycle, so a load in the next instruction reads them.
- Reset values:
  - `uart_tx_valid` = 0, `uart_tx_data` = 0, `trmt_full` = 0
  - `counter_cycle` = 0, `counter_inst` = 0
  - note count = 0, so `note_finished` = 1
  - `leds` = 0
- Reset asserted mid-transfer drops the pending byte. No partial state survives.
- `counter_cycle` counts edges since reset or counter-reset deassertion: the first edge after reset deassertion makes it 1.
- Note of length N with `CLK_COUNTS` = 1: `note_finished` falls the cycle after the write and rises exactly N cycles after the write edge.

## Configuration
- `MMIO_LED_EN` defined: the LED register is implemented at 0x80000030 as above.
- Not defined:
  - `leds` is tied to 6'b0.
  - Stores to 0x80000030 are ignored like any undecoded offset.
  - No LED flops are synthesized.

## Test plan
- **UART handshake:** hold `uart_tx_ready` = 0, store 0x41 to 0x80000008, then store 0x42.
  - Required: `uart_tx_data` = 0x41 and `trmt_full` = 1.
  - Then raise ready for one cycle: valid drops; 0x42 was dropped.
- **Back-to-back UART:** with `uart_tx_ready` = 1 and the holding register full, store 0x55 on the drain cycle.
  - Required: `uart_tx_valid` stays 1 and data becomes 0x55.
- **Counter reset collision:** `inst_retire` = 1 every cycle; store 0x0 to 0x80000018.
  - Required: both counters = 0 the next cycle, then 1, 2, …
  - Preload `counter_cycle` near 0xFFFFFFFF and check the wrap to 0.
- **Note timer:** `CLK_COUNTS` = 1, store 5 with `we` = 4'b1111 to 0x80001000.
  - Required: `note_finished` low 5 cycles, high on cycle 5.
  - Store 3 with `we` = 4'b0011: no effect.
- **Async reset mid-operation:** assert `rst` between edges while the UART is pending and the note is active.
  - Required: all outputs return to reset values immediately, before the next edge.
- **LEDs:** store 0xFFFFFF2A with `we` = 4'b0001 to 0x80000030.
  - With `MMIO_LED_EN`: `leds` = 6'h2A.
  - Without it: `leds` = 0.
